// File: rtl/pc_sequencer.sv
// Program counter with stall, relative branch, absolute jump and halt/resume FSM.
// Optional return-address stack enabled by defining CALL_STACK_EN.
module pc_sequencer #(
    parameter int PC_W      = 8,
    parameter int STEP      = 1,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_offset,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            halt_req,
    input  logic            resume,
`ifdef CALL_STACK_EN
    input  logic            call,
    input  logic            ret,
    output logic            ras_empty,
    output logic            ras_underflow,
`endif
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            wrap
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc_nx;
    logic            wrap_nx;
    logic [PC_W:0]   inc_sum;

    assign inc_sum = {1'b0, pc} + {1'b0, PC_W'(STEP)};

`ifdef CALL_STACK_EN
    localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0] ras_mem [RAS_DEPTH];
    logic [IW-1:0]   wr_ptr, rd_idx, wr_inc;
    logic [CW-1:0]   cnt;
    logic            push, pop, uf_nx;

    // wr_ptr is the next free slot; the circular buffer lets a push when full
    // silently drop the oldest return address.
    assign rd_idx    = (wr_ptr == '0) ? IW'(RAS_DEPTH - 1) : wr_ptr - 1'b1;
    assign wr_inc    = (wr_ptr == IW'(RAS_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign ras_empty = (cnt == '0);
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        wrap_nx  = 1'b0;
`ifdef CALL_STACK_EN
        push     = 1'b0;
        pop      = 1'b0;
        uf_nx    = 1'b0;
`endif
        if (state == RUN) begin
            if (halt_req)
                state_nx = HALTED;
`ifdef CALL_STACK_EN
            if (call) begin
                pc_nx = jump_target;
                push  = 1'b1;
            end else if (ret && !ras_empty) begin
                pc_nx = ras_mem[rd_idx];
                pop   = 1'b1;
            end else if (ret) begin
                pc_nx   = inc_sum[PC_W-1:0];
                wrap_nx = inc_sum[PC_W];
                uf_nx   = 1'b1;
            end else
`endif
            if (jump)
                pc_nx = jump_target;
            else if (br_taken)
                pc_nx = pc + br_offset;
            else if (!stall) begin
                pc_nx   = inc_sum[PC_W-1:0];
                wrap_nx = inc_sum[PC_W];
            end
        end else if (resume && !halt_req) begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= PC_W'(RESET_VEC);
            wrap  <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            wrap  <= wrap_nx;
        end
    end

    assign pc_valid = (state == RUN);

`ifdef CALL_STACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            cnt           <= '0;
            ras_underflow <= 1'b0;
        end else begin
            ras_underflow <= uf_nx;
            if (push) begin
                wr_ptr <= wr_inc;
                if (cnt != CW'(RAS_DEPTH))
                    cnt <= cnt + 1'b1;
            end else if (pop) begin
                wr_ptr <= rd_idx;
                cnt    <= cnt - 1'b1;
            end
        end
    end

    // Entries need no reset: cnt gates every read.
    always_ff @(posedge clk) begin
        if (push)
            ras_mem[wr_ptr] <= inc_sum[PC_W-1:0];
    end
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter block for the single-cycle CPU datapath.
- Replaces the bare increment counter: adds configurable width, step and reset vector, stall, relative branch, absolute jump and a halt/resume state machine.
- Its `pc` output drives the instruction-memory address.
- An optional return-address stack supports call/return.

Parameters:
- PC_W, 8: PC width in bits.
- STEP, 1: increment per sequential fetch (instruction-memory words per instruction).
- RESET_VEC, 0: PC value loaded on reset.
- RAS_DEPTH, 4: return-address stack entries (only used with CALL_STACK_EN).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC this cycle.
- br_taken  input  1  take relative branch.
- br_offset  input  PC_W  signed two's-complement branch offset.
- jump  input  1  take absolute jump.
- jump_target  input  PC_W  absolute jump target.
- halt_req  input  1  request halt.
- resume  input  1  leave HALTED.
- pc  output  PC_W  current fetch address.
- pc_valid  output  1  pc is a valid fetch this cycle.
- wrap  output  1  one-cycle pulse: sequential increment wrapped past all-ones.
- call  input  1  push return address and jump to jump_target (CALL_STACK_EN only).
- ret  input  1  pop return address into pc (CALL_STACK_EN only).
- ras_empty  output  1  stack empty (CALL_STACK_EN only).
- ras_underflow  output  1  one-cycle pulse: ret with empty stack (CALL_STACK_EN only).

Behaviour:
- Reset: reset rst, asynchronous, active-high; clock clk.
  - rst asserted at any time, including mid-branch or while HALTED, immediately forces the following: pc=RESET_VEC, state=RUN, pc_valid=1, wrap=0, ras_empty=1, ras_underflow=0, stack pointer=0.
- FSM states:
  - RUN: pc updates every non-stalled cycle.
  - HALTED: pc frozen, pc_valid=0.
- Transitions:
  - RUN -> HALTED when halt_req=1 at a clock edge. pc still takes that cycle's update, so the instruction in flight completes.
  - HALTED -> RUN when resume=1. pc_valid rises the cycle after the edge.
  - halt_req and resume both high in HALTED: stay HALTED (halt wins).
  - resume in RUN: ignored.
  - In HALTED, all redirect inputs are ignored.
- Next-PC priority in RUN, evaluated at each rising edge, highest first:
  1. jump: pc <= jump_target.
  2. br_taken: pc <= pc + br_offset, modulo 2^PC_W.
  3. stall: pc holds.
  4. otherwise: pc <= pc + STEP, modulo 2^PC_W.
- Redirect under stall: jump/br_taken are taken even when stall=1, so a redirect is never lost.
- Update timing: the PC register updates one edge after its inputs are sampled (latency 1). pc is a pure register output.
- Arithmetic: all sums truncated to PC_W bits, no saturation. A negative br_offset wraps modulo 2^PC_W. br_taken never asserts wrap.
- wrap: asserted for exactly one cycle after a sequential increment whose true sum is >= 2^PC_W.

Optional Feature:
- Macro: CALL_STACK_EN.
- Defined:
  - Priority order becomes call > ret > jump > br_taken > stall > increment.
  - Stack: RAS_DEPTH-entry LIFO of PC_W-bit entries.
  - call: pushes pc+STEP (mod 2^PC_W) and sets pc <= jump_target.
  - Push when full: overwrites the oldest entry (circular); no error flag; depth stays RAS_DEPTH.
  - ret with non-empty stack: pc <= top entry, then pop.
  - ret with empty stack: pc increments normally and ras_underflow pulses for 1 cycle.
  - ras_empty reflects the registered pointer.
  - call and ret are ignored in HALTED.
- Not defined:
  - call, ret, ras_empty and ras_underflow ports are absent.
  - No stack storage is built.

Test Plan:
- Reset and increment (PC_W=8, RESET_VEC=0x10): assert rst mid-count, release, run 3 edges -> pc 0x10, 0x11, 0x12, 0x13; pc_valid=1 throughout.
- Wrap: pc=0xFF, no controls -> pc=0x00 with wrap=1 for one cycle. Then branch from 0xFF with br_offset=1 -> pc=0x00, wrap=0.
- Priority: pc=0x20, stall=1, br_taken=1, br_offset=0xFE (-2) -> pc=0x1E. Next cycle jump=1, br_taken=1, jump_target=0x80 -> pc=0x80. Next cycle stall alone -> pc stays 0x80.
- Halt/resume: halt_req at pc=0x05 -> pc=0x06, pc_valid=0, held 4 cycles with jump=1 ignored. Then resume -> pc=0x07 next edge, pc_valid=1.
- CALL_STACK_EN, RAS_DEPTH=4: call at pc=0x10 to 0x40, then ret -> pc=0x40, then 0x11. Five nested calls followed by five rets -> four correct returns, fifth ret gives ras_underflow=1 and pc increments.
- Async reset mid-HALTED with stack non-empty -> pc=RESET_VEC immediately (before the clock edge), state RUN, ras_empty=1.
